m_unit_sequencer: RTL and testbench

Multi-cycle sequencer for the RV32M extension in the 5-stage core. It accepts one M-type instruction from EX and computes it with a single-cycle registered multiplier or a 32-iteration restoring divider. It drives `busy` into the hazard unit's stall input and holds the result until the writeback slot acknowledges it. It sits beside `execute_stage` and sources `m_unit_result`, `m_unit_dest`, `m_unit_wr`, `m_unit_ready` and `m_unit_busy`.

---
 rtl/m_unit_pkg.sv | 36 +++
 rtl/m_unit_sequencer_div.sv | 76 +++++++
 rtl/m_unit_sequencer.sv | 168 ++++++++++++++++
 tb/tb_m_unit_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/m_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | m_unit_pkg : shared encodings for the RV32M multiply/divide sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package m_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FAST = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  // DIV and REM treat operands as two's complement; DIVU/REMU do not
  function automatic logic f3_div_signed(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_unit_sequencer_div.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | m_div_iter : unsigned restoring divider, one quotient bit per cycle   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module m_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;

  logic [XLEN:0]    w_shift;
  logic [XLEN:0]    w_sub;
  logic [XLEN-1:0]  w_rem_nxt;
  logic [XLEN-1:0]  w_quo_nxt;

  // r_quo starts as the dividend and is shifted out MSB-first while quotient bits enter at the LSB
  always_comb begin
    w_shift   = {r_rem, r_quo[XLEN-1]};
    w_sub     = w_shift - {1'b0, r_div};
    w_rem_nxt = w_shift[XLEN-1:0];
    w_quo_nxt = {r_quo[XLEN-2:0], 1'b0};
    if (!w_sub[XLEN]) begin
      w_rem_nxt = w_sub[XLEN-1:0];
      w_quo_nxt = {r_quo[XLEN-2:0], 1'b1};
    end
  end

  assign done      = r_active && (r_cnt == CNT_W'(XLEN - 1));
  assign quotient  = w_quo_nxt;
  assign remainder = w_rem_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (load) begin
      r_rem    <= '0;
      r_quo    <= dividend;
      r_div    <= divisor;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (abort) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (r_active) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/m_unit_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | m_unit_sequencer : RV32M multi-cycle unit with writeback handshake    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module m_unit_sequencer
  import m_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  input  logic            ack,
  output logic            busy,
  output logic            ready,
  output logic            wr,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dest
);

  state_t          r_state;
  logic [2:0]      r_f3;
  logic [XLEN-1:0] r_op1;
  logic [XLEN-1:0] r_op2;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_busy;
  logic            r_ready;
  logic [XLEN-1:0] r_result;
  logic [4:0]      r_dest;

  logic [2:0]      w_f3;
  logic            w_sgn;
  logic            w_to_div;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_load;
  logic            w_abort;
  logic            w_div_done;
  logic [XLEN-1:0] w_div_q;
  logic [XLEN-1:0] w_div_r;
  logic [XLEN-1:0] w_div_result;
  logic            w_sa;
  logic            w_sb;
  logic signed [2*XLEN+1:0] w_mul_a;
  logic signed [2*XLEN+1:0] w_mul_b;
  logic signed [2*XLEN+1:0] w_prod;
  logic [XLEN-1:0] w_fast_result;
  logic            w_unused;

  assign w_f3  = instruction[14:12];
  assign w_sgn = f3_div_signed(w_f3);

  // Zero divisor and signed overflow have fixed answers and skip the iterative path
  assign w_to_div = f3_is_div(w_f3) && (op2 != '0) &&
                    !(w_sgn && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1));

  assign w_abs1  = (w_sgn && op1[XLEN-1]) ? -op1 : op1;
  assign w_abs2  = (w_sgn && op2[XLEN-1]) ? -op2 : op2;
  assign w_load  = (r_state == ST_IDLE) && start && !flush && w_to_div;
  assign w_abort = (r_state == ST_DIV) && flush;

  m_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .abort    (w_abort),
    .dividend (w_abs1),
    .divisor  (w_abs2),
    .done     (w_div_done),
    .quotient (w_div_q),
    .remainder(w_div_r)
  );

  assign w_div_result = r_f3[1] ? (r_neg_r ? -w_div_r : w_div_r)
                                : (r_neg_q ? -w_div_q : w_div_q);

  assign w_sa    = ((r_f3 == F3_MULH) || (r_f3 == F3_MULHSU)) && r_op1[XLEN-1];
  assign w_sb    = (r_f3 == F3_MULH) && r_op2[XLEN-1];
  assign w_mul_a = {{(XLEN+2){w_sa}}, r_op1};
  assign w_mul_b = {{(XLEN+2){w_sb}}, r_op2};
  assign w_prod  = w_mul_a * w_mul_b;

  always_comb begin
    w_fast_result = w_prod[XLEN-1:0];
    case (r_f3)
      F3_MUL:                      w_fast_result = w_prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fast_result = w_prod[2*XLEN-1:XLEN];
      // In FAST a divide is either by zero or the single overflow case, where the quotient equals op1
      F3_DIV, F3_DIVU:             w_fast_result = (r_op2 == '0) ? '1 : r_op1;
      default:                     w_fast_result = (r_op2 == '0) ? r_op1 : '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_f3     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
      r_dest   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !flush) begin
            r_f3    <= w_f3;
            r_dest  <= instruction[11:7];
            r_op1   <= op1;
            r_op2   <= op2;
            r_neg_q <= w_sgn && (op1[XLEN-1] ^ op2[XLEN-1]);
            r_neg_r <= w_sgn && op1[XLEN-1];
            r_busy  <= 1'b1;
            r_state <= w_to_div ? ST_DIV : ST_FAST;
          end
        end
        ST_FAST: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_result <= w_fast_result;
            r_ready  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_div_done) begin
            r_result <= w_div_result;
            r_ready  <= 1'b1;
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // The op is committed here, so flush has no effect
          if (ack) begin
            r_busy  <= 1'b0;
            r_ready <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign ready  = r_ready;
  assign wr     = r_ready & ack;
  assign result = r_result;
  assign dest   = r_dest;

  assign w_unused = ^{instruction[31:15], instruction[6:0], w_prod[2*XLEN+1:2*XLEN]};

endmodule
`default_nettype wire

// File: tb/tb_m_unit_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_m_unit_sequencer : directed vectors plus a cycle-level reference   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_m_unit_sequencer;
  import m_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] instruction = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic        busy, ready, wr;
  logic [31:0] result;
  logic [4:0]  dest;

  int total = 0;
  int bad   = 0;

  m_unit_sequencer #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .instruction(instruction),
    .op1        (op1),
    .op2        (op2),
    .flush      (flush),
    .ack        (ack),
    .busy       (busy),
    .ready      (ready),
    .wr         (wr),
    .result     (result),
    .dest       (dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = a;
    ib = b;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycle index (issue cycle = 0) on which ready first shows
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
    if (!f3[2] || b == 0) return 2;
    if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
    return 33;
  endfunction

  logic        m_busy = 1'b0;
  logic        m_ready = 1'b0;
  int          m_left = 0;
  logic [31:0] m_result = '0;
  logic [4:0]  m_dest = '0;

  always @(negedge rst) begin
    m_busy   = 1'b0;
    m_ready  = 1'b0;
    m_left   = 0;
    m_result = '0;
    m_dest   = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      if (m_ready) begin
        if (ack) begin
          m_ready = 1'b0;
          m_busy  = 1'b0;
        end
      end else if (m_busy) begin
        if (flush) m_busy = 1'b0;
        else begin
          m_left--;
          if (m_left == 0) m_ready = 1'b1;
        end
      end else if (start && !flush) begin
        m_busy   = 1'b1;
        m_result = ref_result(instruction[14:12], op1, op2);
        m_dest   = instruction[11:7];
        m_left   = ref_latency(instruction[14:12], op1, op2) - 1;
      end
    end
    #2;
    check("cmp_busy", {31'b0, busy}, {31'b0, m_busy});
    check("cmp_ready", {31'b0, ready}, {31'b0, m_ready});
    check("cmp_wr", {31'b0, wr}, {31'b0, m_ready & ack});
    if (m_ready) begin
      check("cmp_result", result, m_result);
      check("cmp_dest", {27'b0, dest}, {27'b0, m_dest});
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    instruction = {FUNC7_MULDIV, 5'd2, 5'd1, f3, rd, 7'b0110011};
    op1   = a;
    op2   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_cyc);
    int cyc;
    issue(f3, a, b, rd);
    cyc = 1;
    check({name, "_busy_c1"}, {31'b0, busy}, 32'd1);
    while (!ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_ready_cycle"}, cyc, exp_cyc);
    check({name, "_result"}, result, exp_res);
    check({name, "_dest"}, {27'b0, dest}, {27'b0, rd});
    check({name, "_wr"}, {31'b0, wr}, {31'b0, ack});
    @(negedge clk);
    check({name, "_busy_after"}, {31'b0, busy}, {31'b0, !ack});
  endtask

  initial begin
    int cyc;
    int wr_seen;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_wr", {31'b0, wr}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_dest", {27'b0, dest}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ack = 1'b1;

    run_op("mul",      F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 2);
    run_op("mulhu",    F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 2);
    run_op("mulhsu",   F3_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFF, 2);
    run_op("mulh",     F3_MULH,   32'h80000000, 32'h80000000, 5'd8,  32'h40000000, 2);
    run_op("div",      F3_DIV,    32'hFFFFFFEC, 32'd3,        5'd10, 32'hFFFFFFFA, 33);
    run_op("rem",      F3_REM,    32'hFFFFFFEC, 32'd3,        5'd11, 32'hFFFFFFFE, 33);
    run_op("divu",     F3_DIVU,   32'd100,      32'd7,        5'd12, 32'd14,       33);
    run_op("remu",     F3_REMU,   32'd100,      32'd7,        5'd13, 32'd2,        33);
    run_op("div_negd", F3_DIV,    32'd7,        32'hFFFFFFFE, 5'd14, 32'hFFFFFFFD, 33);
    run_op("divu_z",   F3_DIVU,   32'd5,        32'd0,        5'd15, 32'hFFFFFFFF, 2);
    run_op("rem_z",    F3_REM,    32'd5,        32'd0,        5'd16, 32'd5,        2);
    run_op("div_ovf",  F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 2);
    run_op("rem_ovf",  F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'd0,        2);

    // Kill an iterative divide partway through
    issue(F3_DIVU, 32'd100, 32'd7, 5'd9);
    cyc = 1;
    while (cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_c11", {31'b0, busy}, 32'd0);
    wr_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (wr) wr_seen++;
    end
    check("flush_no_wr", wr_seen, 32'd0);

    // Hold the result with ack low, poke start, then ack together with flush
    ack = 1'b0;
    run_op("hold_div", F3_DIV, 32'hFFFFFFEC, 32'd3, 5'd20, 32'hFFFFFFFA, 33);
    for (int i = 0; i < 20; i++) begin
      instruction = {FUNC7_MULDIV, 5'd2, 5'd1, F3_MUL, 5'd3, 7'b0110011};
      op1   = 32'd9;
      op2   = 32'd9;
      start = (i % 2) == 0;
      @(negedge clk);
      check("hold_result", result, 32'hFFFFFFFA);
      check("hold_dest", {27'b0, dest}, 32'd20);
      check("hold_wr", {31'b0, wr}, 32'd0);
    end
    start = 1'b0;
    ack   = 1'b1;
    flush = 1'b1;
    #1;
    check("ackflush_wr", {31'b0, wr}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    check("ackflush_busy", {31'b0, busy}, 32'd0);
    check("ackflush_ready", {31'b0, ready}, 32'd0);

    // Asynchronous reset in the middle of a divide
    issue(F3_DIV, 32'hFFFFFFEC, 32'd3, 5'd21);
    cyc = 1;
    while (cyc < 15) begin
      @(negedge clk);
      cyc++;
    end
    rst = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_ready", {31'b0, ready}, 32'd0);
    check("arst_wr", {31'b0, wr}, 32'd0);
    check("arst_result", result, 32'd0);
    check("arst_dest", {27'b0, dest}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_op("post_rst_mul", F3_MUL, 32'd6, 32'd7, 5'd3, 32'd42, 2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
